ips_dbc_capture_ctrl_v1_0: RTL and testbench

Capture sequencer for the debug core's data capture memory. Accepts a per-cycle sample stream and a trigger qualifier, writes samples into the dual-port capture RAM as a circular buffer, holds a programmable pre-trigger window, stops after the post-trigger window, and reports trigger and oldest-sample addresses to the readout logic. Sits between the trigger unit and the capture memory's write port, in the sampled-clock domain.

---
 rtl/ips_dbc_capture_ctrl_v1_0_pkg.sv | 17 +
 rtl/ips_dbc_capture_ctrl_v1_0.sv | 162 ++++++++++++++++
 tb/tb_ips_dbc_capture_ctrl_v1_0.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ips_dbc_capture_ctrl_v1_0_pkg.sv
// Shared types and helpers for the debug-core capture sequencer.
package ips_dbc_capture_ctrl_v1_0_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE_FILL  = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } cap_state_e;

    // Capture buffer depth for a given address width.
    function automatic int unsigned cap_n(input int unsigned depth);
        return 32'd1 << depth;
    endfunction

endpackage

// File: rtl/ips_dbc_capture_ctrl_v1_0.sv
// Capture sequencer: circular-buffer write control with pre/post trigger windows
// for the debug core's capture RAM.
module ips_dbc_capture_ctrl_v1_0
    import ips_dbc_capture_ctrl_v1_0_pkg::*;
#(
    parameter int unsigned DATA_DEPTH = 9,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_DEPTH-1:0] pre_trig_len,
    input  logic                  sample_en,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  trig,
    output logic                  mem_wren,
    output logic [DATA_DEPTH-1:0] mem_wraddr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [DATA_DEPTH-1:0] trig_addr,
    output logic [DATA_DEPTH-1:0] start_addr
);

    localparam int unsigned CNT_W = DATA_DEPTH + 1;
    localparam int unsigned N     = cap_n(DATA_DEPTH);

    cap_state_e            state, state_nxt;
    logic [DATA_DEPTH-1:0] ptr, ptr_nxt;
    logic [DATA_DEPTH-1:0] pre_cnt, pre_cnt_nxt;
    logic [CNT_W-1:0]      post_cnt, post_cnt_nxt;
    logic [DATA_DEPTH-1:0] p_len, p_len_nxt;
    logic [CNT_W-1:0]      post_target;

    logic                  wren_nxt;
    logic [DATA_DEPTH-1:0] wraddr_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  busy_nxt, triggered_nxt, done_nxt;
    logic [DATA_DEPTH-1:0] trig_addr_nxt, start_addr_nxt;
    logic                  write;

    // Post-trigger window length N-P, ranges 1..N.
    assign post_target = CNT_W'(N) - CNT_W'(p_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            p_len      <= '0;
            mem_wren   <= 1'b0;
            mem_wraddr <= '0;
            mem_data   <= '0;
            busy       <= 1'b0;
            triggered  <= 1'b0;
            done       <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            pre_cnt    <= pre_cnt_nxt;
            post_cnt   <= post_cnt_nxt;
            p_len      <= p_len_nxt;
            mem_wren   <= wren_nxt;
            mem_wraddr <= wraddr_nxt;
            mem_data   <= data_nxt;
            busy       <= busy_nxt;
            triggered  <= triggered_nxt;
            done       <= done_nxt;
            trig_addr  <= trig_addr_nxt;
            start_addr <= start_addr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        pre_cnt_nxt    = pre_cnt;
        post_cnt_nxt   = post_cnt;
        p_len_nxt      = p_len;
        wren_nxt       = 1'b0;
        wraddr_nxt     = mem_wraddr;
        data_nxt       = mem_data;
        triggered_nxt  = triggered;
        trig_addr_nxt  = trig_addr;
        start_addr_nxt = start_addr;
        write          = 1'b0;

        // Abort overrides everything, including a simultaneous arm or sample.
        if (abort) begin
            state_nxt     = ST_IDLE;
            triggered_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        p_len_nxt      = pre_trig_len;
                        ptr_nxt        = '0;
                        pre_cnt_nxt    = '0;
                        post_cnt_nxt   = '0;
                        triggered_nxt  = 1'b0;
                        trig_addr_nxt  = '0;
                        start_addr_nxt = '0;
                        state_nxt      = (pre_trig_len == '0) ? ST_WAIT_TRIG : ST_PRE_FILL;
                    end
                end
                ST_PRE_FILL: begin
                    if (sample_en) begin
                        write       = 1'b1;
                        pre_cnt_nxt = pre_cnt + DATA_DEPTH'(1);
                        if (pre_cnt_nxt == p_len) begin
                            state_nxt = ST_WAIT_TRIG;
                        end
                    end
                end
                ST_WAIT_TRIG: begin
                    if (sample_en) begin
                        write = 1'b1;
                        if (trig) begin
                            trig_addr_nxt = ptr;
                            triggered_nxt = 1'b1;
                            post_cnt_nxt  = CNT_W'(1);
                            if (post_target == CNT_W'(1)) begin
                                state_nxt      = ST_DONE;
                                start_addr_nxt = ptr - p_len;
                            end else begin
                                state_nxt = ST_POST;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (sample_en) begin
                        write        = 1'b1;
                        post_cnt_nxt = post_cnt + CNT_W'(1);
                        if (post_cnt_nxt == post_target) begin
                            state_nxt      = ST_DONE;
                            start_addr_nxt = trig_addr - p_len;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        if (write) begin
            wren_nxt   = 1'b1;
            wraddr_nxt = ptr;
            data_nxt   = sample_data;
            ptr_nxt    = ptr + DATA_DEPTH'(1);
        end

        busy_nxt = (state_nxt == ST_PRE_FILL) || (state_nxt == ST_WAIT_TRIG) ||
                   (state_nxt == ST_POST);
        done_nxt = (state_nxt == ST_DONE);
    end

endmodule

// File: tb/tb_ips_dbc_capture_ctrl_v1_0.sv
// Scoreboard bench for the capture sequencer at DATA_DEPTH=4 (N=16).
module tb_ips_dbc_capture_ctrl_v1_0;

    localparam int unsigned DD = 4;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst_n;
    logic          arm;
    logic          abort;
    logic [DD-1:0] pre_trig_len;
    logic          sample_en;
    logic [DW-1:0] sample_data;
    logic          trig;
    logic          mem_wren;
    logic [DD-1:0] mem_wraddr;
    logic [DW-1:0] mem_data;
    logic          busy;
    logic          triggered;
    logic          done;
    logic [DD-1:0] trig_addr;
    logic [DD-1:0] start_addr;

    ips_dbc_capture_ctrl_v1_0 #(.DATA_DEPTH(DD), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arm          (arm),
        .abort        (abort),
        .pre_trig_len (pre_trig_len),
        .sample_en    (sample_en),
        .sample_data  (sample_data),
        .trig         (trig),
        .mem_wren     (mem_wren),
        .mem_wraddr   (mem_wraddr),
        .mem_data     (mem_data),
        .busy         (busy),
        .triggered    (triggered),
        .done         (done),
        .trig_addr    (trig_addr),
        .start_addr   (start_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    logic [DD+DW-1:0] exp_q[$];
    int unsigned      exp_k    = 0;
    logic [DW-1:0]    data_ctr = '0;

    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Monitor: every presented write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && mem_wren) begin
            logic [DD+DW-1:0] got;
            logic [DD+DW-1:0] want;
            got = {mem_wraddr, mem_data};
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                         mem_wraddr, mem_data);
            end else begin
                want = exp_q.pop_front();
                if (got == want) n_pass++;
                else $display("FAIL write: got addr %0d data %0d expected addr %0d data %0d",
                              mem_wraddr, mem_data, want[DD+DW-1:DW], want[DW-1:0]);
            end
        end
    end

    // One clock: drive at negedge, advance to the next negedge.
    task automatic cyc(input logic en, input logic tg, input logic a, input logic ab,
                       input int unsigned p, input bit exp_wr);
        sample_en    = en;
        trig         = tg;
        arm          = a;
        abort        = ab;
        pre_trig_len = DD'(p);
        sample_data  = data_ctr;
        if (exp_wr) begin
            exp_q.push_back({DD'(exp_k % 16), data_ctr});
            exp_k++;
        end
        @(posedge clk);
        if (en) data_ctr = data_ctr + 8'd1;
        @(negedge clk);
        sample_en = 1'b0;
        trig      = 1'b0;
        arm       = 1'b0;
        abort     = 1'b0;
    endtask

    // Full capture: every sample from arm to done is expected to be written.
    task automatic run_capture(input string nm, input int unsigned p, input int unsigned early,
                               input int unsigned tidx, input int unsigned total, input bit gap,
                               input int unsigned arm_at, input int unsigned exp_ta,
                               input int unsigned exp_sa);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, p, 1'b0);
        exp_k = 0;
        check({nm, "_arm_busy"}, busy, 1);
        check({nm, "_arm_done"}, done, 0);
        check({nm, "_arm_trig"}, triggered, 0);
        for (int i = 1; i <= total; i++) begin
            if (gap) cyc(1'b0, 1'b1, 1'b0, 1'b0, p, 1'b0);
            cyc(1'b1, (i == tidx) || (i <= early), (i == arm_at), 1'b0,
                (i == arm_at) ? 10 : p, 1'b1);
            if (i == total - 1 || i == total) begin
                check({nm, "_done"}, done, (i == total) ? 1 : 0);
                check({nm, "_busy"}, busy, (i == total) ? 0 : 1);
            end
            if (i == tidx - 1 || i == tidx) check({nm, "_triggered"}, triggered, (i >= tidx) ? 1 : 0);
        end
        check({nm, "_trig_addr"}, trig_addr, exp_ta);
        check({nm, "_start_addr"}, start_addr, exp_sa);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, p, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, p, 1'b0);
        check({nm, "_done_held"}, done, 1);
        check({nm, "_q_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        arm = 1'b0; abort = 1'b0; pre_trig_len = '0;
        sample_en = 1'b0; sample_data = '0; trig = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wren", mem_wren, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_wraddr", mem_wraddr, 0);
        check("rst_data", mem_data, 0);
        check("rst_triggered", triggered, 0);
        check("rst_done", done, 0);
        check("rst_trig_addr", trig_addr, 0);
        check("rst_start_addr", start_addr, 0);

        // P=4, trigger on 10th sample: 4 pre + 5 wait + 12 post writes.
        run_capture("p4", 4, 0, 10, 21, 1'b0, 0, 9, 5);
        // P=0: trigger on the very first sample.
        run_capture("p0", 0, 0, 1, 16, 1'b0, 0, 0, 0);
        // P=15, 40 wait samples then trigger: wraps, single post sample.
        run_capture("p15", 15, 0, 56, 56, 1'b0, 0, 7, 8);
        // P=4, trig on pre samples 1-3 ignored; accepted on sample 5.
        run_capture("pre_ign", 4, 3, 5, 16, 1'b0, 0, 4, 0);
        // P=8 with sample_en every other cycle.
        run_capture("gap", 8, 0, 9, 16, 1'b1, 0, 8, 0);

        // Abort during POST together with arm.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b0);
        exp_k = 0;
        for (int i = 1; i <= 7; i++) cyc(1'b1, (i == 5), 1'b0, 1'b0, 4, 1'b1);
        check("abort_pre_trig", triggered, 1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_triggered", triggered, 0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4, 1'b0);
        check("abort_idle_busy", busy, 0);
        check("abort_q_empty", exp_q.size(), 0);
        // P=2 capture with a second arm (P=10) on sample 2 that must be ignored.
        run_capture("arm_busy", 2, 0, 3, 16, 1'b0, 2, 2, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
